// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- load/store unit in front of a word-addressed unified memory.
//
// Accepts byte, halfword and word loads and stores from the datapath. The unit
// drives the memory's write enable, address and write data. It consumes the
// memory's combinational read data for the addressed word.
//
// The memory only writes whole words. Byte and halfword stores therefore run
// as read-modify-write: read the word, splice in the new lane(s), write back.
// Loaded bytes and halfwords are extracted from their little-endian lane and
// sign- or zero-extended to 32 bits.
//
// Ports
//   clk_i           clock, all state on the rising edge
//   rst_ni          asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     unit idle; request accepted on an edge with valid & ready
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr_i      byte address
//   req_wdata_i     store data, right-justified
//   rsp_valid_o     one-cycle completion pulse (no backpressure)
//   rsp_rdata_o     extended load data, 0 for stores and rejected requests
//   rsp_misalign_o  request rejected (misaligned or illegal size)
//   mem_we_o        memory write enable
//   mem_addr_o      word-aligned memory address
//   mem_wdata_o     full word to write
//   mem_rdata_i     combinational read data at mem_addr_o
// -----------------------------------------------------------------------------
module mem_lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_misalign_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        is_unsigned,
    input logic [1:0]  offset
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
      SIZE_HALF: r = {{16{~is_unsigned & h[15]}}, h};
      SIZE_WORD: r = word;
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Overlay the store lane(s) onto the word just read from memory.
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  offset,
    input logic [15:0] wdata
  );
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          2'd3:    r[31:24] = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) begin
          r[31:16] = wdata;
        end else begin
          r[15:0]  = wdata;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  // Only the low half is needed later. Word stores load the merge register
  // directly at acceptance.
  logic [15:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        mem_we_q;

  logic        misalign_s;
  logic [31:0] load_data_s;
  logic [31:0] merge_data_s;

  // Classify the incoming request and pre-compute the lane extract/merge values.
  always_comb begin
    misalign_s = (req_size_i == 2'b11)
               | ((req_size_i == SIZE_HALF) & req_addr_i[0])
               | ((req_size_i == SIZE_WORD) & (req_addr_i[1:0] != 2'b00));
    load_data_s  = load_extract(mem_rdata_i, size_q, unsigned_q, addr_q[1:0]);
    merge_data_s = store_merge(mem_rdata_i, size_q, addr_q[1:0], wdata_q);
  end

  // Next-state decode for the request FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (misalign_s) begin
            state_d = ST_RESP;
          end else if (!req_we_i) begin
            state_d = ST_LOAD;
          end else if (req_size_i == SIZE_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD:     state_d = ST_RESP;
      ST_RMW_READ: state_d = ST_WRITE;
      ST_WRITE:    state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM state, request capture and registered outputs.
  // The ready, response-valid and write-enable flops are one-hot copies of the
  // next state. Each output is therefore a clean flop output that drops as
  // soon as reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 16'h0000;
      merge_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      misalign_q  <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      mem_we_q    <= (state_d == ST_WRITE);
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i[15:0];
            rdata_q    <= 32'h0000_0000;
            misalign_q <= misalign_s;
            // A word store skips the read phase and writes the data as is.
            if (req_we_i && (req_size_i == SIZE_WORD)) begin
              merge_q <= req_wdata_i;
            end else begin
              merge_q <= merge_q;
            end
          end else begin
            misalign_q <= 1'b0;
          end
        end
        ST_LOAD:     rdata_q <= load_data_s;
        ST_RMW_READ: merge_q <= merge_data_s;
        ST_WRITE:    merge_q <= merge_q;
        // The reject flag means something only alongside the response pulse.
        ST_RESP:     misalign_q <= misalign_q;
        default:     misalign_q <= 1'b0;
      endcase
    end
  end

  assign req_ready_o    = ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_misalign_o = misalign_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = {addr_q[31:2], 2'b00};
  assign mem_wdata_o    = merge_q;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu -- directed self-checking bench for mem_lsu.
// A small behavioural word memory sits behind the unit. Expected response
// data, latencies and memory contents are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

  logic        clk;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_count = 0;

  int vectors = 0;
  int miscompares = 0;

  mem_lsu dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_misalign_o (rsp_misalign),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write at the clock edge; the
  // backdoor port preloads contents.
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request. Latencies count cycles after the acceptance cycle.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_mis,
                         input logic [31:0] exp_rdata, input int exp_we_at,
                         input string tag);
    int lat;
    int we_at;
    int we_cnt;
    logic [31:0] rd;
    logic mis;
    lat = 0; we_at = 0; we_cnt = 0; rd = 32'h0; mis = 1'b0;
    @(negedge clk);
    check({31'd0, req_ready}, 32'd1, {tag, "_ready"});
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; (k <= 8) && (lat == 0); k++) begin
      if (k > 1) @(negedge clk);
      if (mem_we) begin we_cnt++; we_at = k; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; mis = rsp_misalign; end
    end
    check(lat, exp_lat, {tag, "_latency"});
    check({31'd0, mis}, {31'd0, exp_mis}, {tag, "_misalign"});
    check(rd, exp_rdata, {tag, "_rdata"});
    check(we_cnt, (exp_we_at != 0) ? 32'd1 : 32'd0, {tag, "_we_count"});
    check(we_at, exp_we_at, {tag, "_we_cycle"});
    @(negedge clk);
    check({30'd0, rsp_valid, req_ready}, 32'd1, {tag, "_pulse_end"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({31'd0, req_ready},    32'd1, {tag, "_ready"});
    check({31'd0, rsp_valid},    32'd0, {tag, "_rsp_valid"});
    check(rsp_rdata,             32'd0, {tag, "_rsp_rdata"});
    check({31'd0, rsp_misalign}, 32'd0, {tag, "_rsp_misalign"});
    check({31'd0, mem_we},       32'd0, {tag, "_mem_we"});
    check(mem_addr,              32'd0, {tag, "_mem_addr"});
    check(mem_wdata,             32'd0, {tag, "_mem_wdata"});
  endtask

  initial begin
    int wr0;
    rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bd_we = 1'b0; bd_idx = 4'd0; bd_data = 32'h0;

    // Preload the memory while reset is held.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = i[3:0];
      bd_data = (i == 4) ? 32'h8001_7FFF : (i == 5) ? 32'h1122_3344 : 32'h0;
    end
    @(negedge clk);
    bd_we = 1'b0;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Loads from 0x10 = 0x80017FFF.
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF80, 0, "lb_13");
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'h0000_0080, 0, "lbu_13");
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0000_7FFF, 0, "lh_10");
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_8001, 0, "lh_12");
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'h0000_8001, 0, "lhu_12");

    // Sub-word stores into 0x14 = 0x11223344.
    run_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB, 3, 1'b0, 32'h0, 2, "sb_15");
    check(mem[5], 32'h1122_AB44, "sb_15_word");
    run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, 3, 1'b0, 32'h0, 2, "sh_16");
    check(mem[5], 32'hBEEF_AB44, "sh_16_word");

    // Word store then load back.
    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 1, "sw_20");
    check(mem[8], 32'hDEAD_BEEF, "sw_20_word");
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0, "lw_20");

    // Rejected requests: no write, memory untouched.
    wr0 = wr_count;
    run_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 1'b1, 32'h0, 0, "lw_22_mis");
    run_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_1234, 1, 1'b1, 32'h0, 0, "sh_21_mis");
    run_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h5555_5555, 1, 1'b1, 32'h0, 0, "size11_mis");
    check(wr_count, wr0, "mis_no_writes");
    check(mem[8], 32'hDEAD_BEEF, "mis_word_20");

    // Reset pulsed while a halfword store sits in RMW_READ.
    wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h16; req_wdata = 32'h0000_1234;
    @(negedge clk);
    req_valid = 1'b0;
    check({31'd0, req_ready}, 32'd0, "rst_busy");
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    check(wr_count, wr0, "rst_no_write");
    check(mem[5], 32'hBEEF_AB44, "rst_word_14");
    check({31'd0, req_ready}, 32'd1, "rst_ready_after");
    check({31'd0, rsp_valid}, 32'd0, "rst_no_rsp");

    // Back-to-back loads with valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0;
    @(negedge clk);                               // n+1: first in LOAD
    req_addr = 32'h10;
    check({30'd0, req_ready, rsp_valid}, 32'd0, "b2b_c1");
    @(negedge clk);                               // n+2: first RESP
    check({30'd0, req_ready, rsp_valid}, 32'd1, "b2b_c2");
    check(rsp_rdata, 32'hDEAD_BEEF, "b2b_rdata1");
    @(negedge clk);                               // n+3: idle, second accepted
    check({30'd0, req_ready, rsp_valid}, 32'd2, "b2b_c3");
    @(negedge clk);                               // n+4: second in LOAD
    req_valid = 1'b0;
    check({30'd0, req_ready, rsp_valid}, 32'd0, "b2b_c4");
    @(negedge clk);                               // n+5: second RESP
    check({30'd0, req_ready, rsp_valid}, 32'd1, "b2b_c5");
    check(rsp_rdata, 32'h8001_7FFF, "b2b_rdata2");
    check({31'd0, rsp_misalign}, 32'd0, "b2b_misalign");
    @(negedge clk);
    check({30'd0, req_ready, rsp_valid}, 32'd2, "b2b_c6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit sitting directly upstream of the multicycle processor's word-addressed unified memory. It accepts byte, halfword and word load/store requests from the datapath. It drives the memory's write enable, address and write data, and consumes its combinational read data. Sub-word stores are done as read-modify-write, since the memory only writes whole words. Loaded bytes and halfwords are extracted and sign- or zero-extended.

## Interface
- No parameters; data and address width fixed at 32, little-endian byte lanes.
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit idle, request accepted on edge where valid&ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i2  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr_i32  in  32  byte address
- req_wdata_i32  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid_o  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata_o32  out  32  extended load data; 0 for stores
- rsp_misalign_o  out  1  request rejected (misaligned or illegal size)
- mem_we_o  out  1  memory write enable
- mem_addr_o32  out  32  word-aligned address {addr_q[31:2],2'b00}
- mem_wdata_o32  out  32  full word to write
- mem_rdata_i32  in  32  memory combinational read data at mem_addr_o32

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP. req_ready_o = (state==IDLE).
- IDLE, on valid&ready: latch we, size, unsigned, addr, wdata. Next state:
  - RESP with misalign flag: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
  - LOAD: aligned load.
  - WRITE: word store; write word = wdata.
  - RMW_READ: byte/half store.
- LOAD: capture extracted/extended mem_rdata_i32 into rsp data -> RESP.
  - Byte lane = addr[1:0].
  - Half lane = addr[1]: bits [15:0] or [31:16].
  - Word passes unchanged.
- RMW_READ: merge register = mem_rdata_i32 with the target lane(s) replaced by wdata[7:0] or wdata[15:0] -> WRITE.
- WRITE: mem_we_o=1, mem_wdata_o32 = merge register; memory updates at end of this cycle -> RESP.
- RESP: rsp_valid_o=1 for exactly one cycle -> IDLE. rsp_misalign_o valid only with rsp_valid_o.
- Misaligned/illegal requests never assert mem_we_o and never alter memory.
- mem_we_o is decoded from the state register only, so it is glitch-free and drops immediately on reset.
- req_valid_i while ready is low is ignored. The requester must hold the request until accepted.

## Timing
- Acceptance edge in cycle n. rsp_valid_o high in cycle:
  - n+1: misaligned/illegal.
  - n+2: load or word store.
  - n+3: byte/half store.
- Next request accepted no earlier than the cycle after RESP.
- Throughput: one request per 2/3/4 cycles (misaligned / load or word store / sub-word store).
- mem_we_o high exactly one cycle per legal store.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o32=0, rsp_misalign_o=0, mem_we_o=0, mem_addr_o32=0, mem_wdata_o32=0.
- Reset mid-operation: unit returns to IDLE asynchronously and any pending response is dropped.
  - If reset is asserted before the WRITE-cycle edge, no memory write occurs.
- A load issued after a store's RESP observes the stored data.

## Test plan
- Word 0x10 = 0x80017FFF:
  - lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080.
  - lh 0x10 -> 0x00007FFF; lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
  - Each load: rsp at n+2, mem_we_o never high.
- Word 0x14 = 0x11223344:
  - sb 0x15 data 0x000000AB -> word 0x1122AB44, mem_we_o high one cycle at n+2, rsp at n+3.
  - sh 0x16 data 0x0000BEEF -> word 0xBEEFAB44.
- sw 0x20 0xDEADBEEF (rsp n+2, rsp_rdata 0) then lw 0x20 -> 0xDEADBEEF.
- lw 0x22, sh 0x21, size 11 at 0x20:
  - Each -> rsp_misalign_o=1 at n+1, mem_we_o stays 0, word 0x20 unchanged.
- sh 0x16 issued, rst_ni pulsed low during RMW_READ:
  - mem_we_o never asserted, all outputs at reset values, word 0x14 unchanged.
  - req_ready_o=1 after release.
- req_valid_i held high across back-to-back lw 0x20 / lw 0x10:
  - Second request ignored while ready low, accepted the cycle after first RESP.
  - Responses in order with correct data.
